agc_ctl: RTL



---
 rtl/agc_ctl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/agc_ctl.sv
// Windowed AGC loop: latches the detector peak each window, clears the detector, steps the gain.
// Optional macro AGC_FAST_ATTACK_EN: a clipped peak (2047) attacks by 4 codes instead of 1.
module agc_ctl #(
  parameter int unsigned PERIOD = 1024,
  parameter int unsigned HANG   = 8,
  parameter int unsigned HI     = 1448,
  parameter int unsigned LO     = 724,
  parameter int unsigned GINIT  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [10:0] max,
  input  logic        hold,
  output logic        pclr,
  output logic [10:0] peak,
  output logic [5:0]  gain,
  output logic        upd,
  output logic        hang
);

  localparam int unsigned DATA_W = 11;
  localparam int unsigned GAIN_W = 6;

  localparam logic [15:0]       WEND   = 16'(PERIOD - 1);
  localparam logic [DATA_W-1:0] HI_V   = DATA_W'(HI);
  localparam logic [DATA_W-1:0] LO_V   = DATA_W'(LO);
  localparam logic [7:0]        HANG_V = 8'(HANG);
  localparam logic [GAIN_W-1:0] GINIT_V = GAIN_W'(GINIT);

  typedef enum logic {ST_TRACK, ST_HANG} state_t;

  function automatic logic [GAIN_W-1:0] gain_dec(input logic [GAIN_W-1:0] g,
                                                 input logic [2:0] step);
    logic [GAIN_W-1:0] s;
    s = {{(GAIN_W-3){1'b0}}, step};
    return (g > s) ? g - s : '0;
  endfunction

  function automatic logic [GAIN_W-1:0] gain_inc(input logic [GAIN_W-1:0] g);
    return (g == '1) ? g : g + 1'b1;
  endfunction

  logic [15:0]       wcnt_q, wcnt_d;
  logic [DATA_W-1:0] peak_q, peak_d;
  logic              pclr_q, pclr_d;
  logic              eval_q, eval_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic              upd_q, upd_d;
  logic [7:0]        hcnt_q, hcnt_d;
  state_t            state_q, state_d;
  logic              wrap;
  logic [2:0]        atk_step;

`ifdef AGC_FAST_ATTACK_EN
  assign atk_step = (peak_q == '1) ? 3'd4 : 3'd1;
`else
  assign atk_step = 3'd1;
`endif

  assign wrap = ce && (wcnt_q == WEND);

  // window boundary: latch peak and issue clear/eval pulses
  always_comb begin
    wcnt_d = wcnt_q;
    peak_d = peak_q;
    if (ce) wcnt_d = wrap ? '0 : wcnt_q + 16'd1;
    if (wrap) peak_d = max;
    pclr_d = wrap;
    eval_d = wrap;
  end

  // gain evaluation one cycle after the boundary, on the freshly latched peak
  always_comb begin
    gain_d  = gain_q;
    hcnt_d  = hcnt_q;
    state_d = state_q;
    upd_d   = 1'b0;
    if (eval_q && !hold) begin
      if (peak_q > HI_V) begin
        gain_d  = gain_dec(gain_q, atk_step);
        hcnt_d  = HANG_V;
        state_d = (HANG_V == 8'd0) ? ST_TRACK : ST_HANG;
      end else if (peak_q < LO_V) begin
        if (state_q == ST_HANG) begin
          if (hcnt_q <= 8'd1) begin
            hcnt_d  = '0;
            state_d = ST_TRACK;
          end else begin
            hcnt_d = hcnt_q - 8'd1;
          end
        end else begin
          gain_d = gain_inc(gain_q);
        end
      end
      upd_d = (gain_d != gain_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q  <= '0;
      peak_q  <= '0;
      pclr_q  <= 1'b1;
      eval_q  <= 1'b0;
      gain_q  <= GINIT_V;
      upd_q   <= 1'b0;
      hcnt_q  <= '0;
      state_q <= ST_TRACK;
    end else begin
      wcnt_q  <= wcnt_d;
      peak_q  <= peak_d;
      pclr_q  <= pclr_d;
      eval_q  <= eval_d;
      gain_q  <= gain_d;
      upd_q   <= upd_d;
      hcnt_q  <= hcnt_d;
      state_q <= state_d;
    end
  end

  assign pclr = pclr_q;
  assign peak = peak_q;
  assign gain = gain_q;
  assign upd  = upd_q;
  assign hang = (state_q == ST_HANG);

endmodule
